pq_buffer_ctrl: RTL and testbench

- Sequencing controller for the two-bank ping-pong buffer (`pq_buffer`).
- Accepts a producer stream with a valid/ready handshake and packs it into frames of a configurable length.
- Generates `ctrl`, `wr_en`/`wr_addr`, `rd_en`/`rd_addr` for the buffer, and swaps banks when one bank is filled and the other is drained.
- Emits a read-data-valid strobe aligned with the buffer's registered output mux.

---
 rtl/pq_buffer_ctrl_if.sv | 57 +++++
 rtl/pq_buffer_ctrl.sv | 138 +++++++++++++
 tb/tb_pq_buffer_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pq_buffer_ctrl_if.sv
// Ping-pong buffer controller bundle.
// Producer, consumer and buffer-control signals.
interface pq_buffer_ctrl_if #(
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH:0]   cfg_len;
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic                  out_req;
  logic                  ctrl;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_data_valid;
  logic                  rd_data_last;
  logic                  wr_frame_done;
  logic                  rd_frame_done;
  logic                  busy;

  modport master (
    input  cfg_len,
    input  flush,
    input  in_valid,
    output in_ready,
    input  out_req,
    output ctrl,
    output wr_en,
    output wr_addr,
    output rd_en,
    output rd_addr,
    output rd_data_valid,
    output rd_data_last,
    output wr_frame_done,
    output rd_frame_done,
    output busy
  );

  modport slave (
    output cfg_len,
    output flush,
    output in_valid,
    input  in_ready,
    output out_req,
    input  ctrl,
    input  wr_en,
    input  wr_addr,
    input  rd_en,
    input  rd_addr,
    input  rd_data_valid,
    input  rd_data_last,
    input  wr_frame_done,
    input  rd_frame_done,
    input  busy
  );
endinterface

// File: rtl/pq_buffer_ctrl.sv
// Ping-pong buffer sequencing controller.
// Packs a stream into frames, swaps banks, aligns read valid.
module pq_buffer_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int RD_LAT     = 2
) (
  input  logic clk,
  input  logic rst,
  pq_buffer_ctrl_if.master bus
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH =
    {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [CW-1:0] ONE =
    {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic              ctrl_q;
  logic              wfull;
  logic              rfull;
  logic [CW-1:0]     wcnt;
  logic [CW-1:0]     rcnt;
  logic [CW-1:0]     wlen;
  logic [CW-1:0]     rlen;
  logic [RD_LAT-1:0] vsr;
  logic [RD_LAT-1:0] lsr;

  logic [CW-1:0]     len_clamp;
  logic [CW-1:0]     wlen_use;
  logic [CW-1:0]     wcnt_inc;
  logic [CW-1:0]     rcnt_inc;
  logic              in_rdy;
  logic              wr_go;
  logic              wr_last;
  logic              rd_go;
  logic              rd_last;
  logic              swap;

  // Clamp the requested frame length into 1..DEPTH.
  always_comb begin
    len_clamp = bus.cfg_len;
    if (bus.cfg_len == '0 || bus.cfg_len > DEPTH)
      len_clamp = DEPTH;
  end

  // A frame's first word already sees its new length.
  assign wlen_use = (wcnt == '0) ? len_clamp : wlen;
  assign wcnt_inc = wcnt + ONE;
  assign rcnt_inc = rcnt + ONE;

  assign in_rdy  = !wfull && !bus.flush;
  assign wr_go   = bus.in_valid && in_rdy;
  assign wr_last = wr_go && (wcnt_inc == wlen_use);

  assign rd_go   = rfull && bus.out_req && !bus.flush;
  assign rd_last = rd_go && (rcnt_inc == rlen);

  // Both sides idle-or-done: hand the full bank over.
  assign swap    = wfull && !rfull && !bus.flush;

  // Write-side fill counter and full flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt  <= '0;
      wfull <= 1'b0;
      wlen  <= DEPTH;
    end else if (bus.flush) begin
      wcnt  <= '0;
      wfull <= 1'b0;
    end else if (wr_go) begin
      if (wcnt == '0)
        wlen <= len_clamp;
      if (wr_last) begin
        wcnt  <= '0;
        wfull <= 1'b1;
      end else begin
        wcnt  <= wcnt_inc;
      end
    end else if (swap) begin
      wfull <= 1'b0;
    end
  end

  // Read-side drain counter, full flag and bank select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt   <= '0;
      rfull  <= 1'b0;
      rlen   <= DEPTH;
      ctrl_q <= 1'b0;
    end else if (bus.flush) begin
      rcnt   <= '0;
      rfull  <= 1'b0;
    end else if (swap) begin
      ctrl_q <= ~ctrl_q;
      rfull  <= 1'b1;
      rlen   <= wlen;
    end else if (rd_go) begin
      if (rd_last) begin
        rcnt  <= '0;
        rfull <= 1'b0;
      end else begin
        rcnt  <= rcnt_inc;
      end
    end
  end

  // Delay issue/last to line up with the buffer dout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsr <= '0;
      lsr <= '0;
    end else begin
      vsr[0] <= rd_go;
      lsr[0] <= rd_last;
      for (int i = 1; i < RD_LAT; i++) begin
        vsr[i] <= vsr[i-1];
        lsr[i] <= lsr[i-1];
      end
    end
  end

  assign bus.in_ready      = in_rdy;
  assign bus.ctrl          = ctrl_q;
  assign bus.wr_en         = wr_go;
  assign bus.wr_addr       = wcnt[ADDR_WIDTH-1:0];
  assign bus.rd_en         = rd_go;
  assign bus.rd_addr       = rcnt[ADDR_WIDTH-1:0];
  assign bus.rd_data_valid = vsr[RD_LAT-1];
  assign bus.rd_data_last  = lsr[RD_LAT-1];
  assign bus.wr_frame_done = wr_last;
  assign bus.rd_frame_done = rd_last;
  assign bus.busy          = wfull | rfull
                           | (wcnt != '0)
                           | (rcnt != '0)
                           | (|vsr);

endmodule

// File: tb/tb_pq_buffer_ctrl.sv
// Directed bench for the ping-pong controller.
// Hand-computed cycle expectations per scenario.
module tb_pq_buffer_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pq_buffer_ctrl_if #(.ADDR_WIDTH(4)) bus ();

  pq_buffer_ctrl #(
    .ADDR_WIDTH(4),
    .RD_LAT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.out_req  = 1'b0;
    bus.flush    = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.cfg_len  = '0;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_req  = 1'b0;

    // power-on reset state
    @(negedge clk);
    chk("por_in_ready", bus.in_ready, 1);
    chk("por_busy", bus.busy, 0);
    chk("por_ctrl", bus.ctrl, 0);
    chk("por_wr_en", bus.wr_en, 0);
    chk("por_rd_en", bus.rd_en, 0);
    chk("por_rdv", bus.rd_data_valid, 0);
    tick();
    rst = 1'b0;

    // single frame of 4
    bus.cfg_len  = 5'd4;
    bus.out_req  = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("sf_wr_en", bus.wr_en, 1);
      chk("sf_wr_addr", bus.wr_addr, i);
      chk("sf_ctrl_w", bus.ctrl, 0);
      chk("sf_wfd", bus.wr_frame_done, i == 3);
      tick();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("sf_swap_rdy", bus.in_ready, 0);
    chk("sf_swap_ctrl", bus.ctrl, 0);
    chk("sf_swap_rd", bus.rd_en, 0);
    tick();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("sf_ctrl_r", bus.ctrl, 1);
      chk("sf_rd_en", bus.rd_en, i < 4);
      if (i < 4)
        chk("sf_rd_addr", bus.rd_addr, i);
      chk("sf_rfd", bus.rd_frame_done, i == 3);
      chk("sf_rdv", bus.rd_data_valid,
          i >= 2 && i < 6);
      chk("sf_rdl", bus.rd_data_last, i == 5);
      tick();
    end
    @(negedge clk);
    chk("sf_end_rdv", bus.rd_data_valid, 0);
    chk("sf_end_busy", bus.busy, 0);
    tick();

    // async reset mid-frame with ctrl=1
    bus.cfg_len  = 5'd8;
    bus.in_valid = 1'b1;
    bus.out_req  = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    @(negedge clk);
    chk("rst_pre_addr", bus.wr_addr, 5);
    chk("rst_pre_ctrl", bus.ctrl, 1);
    chk("rst_pre_busy", bus.busy, 1);
    #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_ctrl", bus.ctrl, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_rdv", bus.rd_data_valid, 0);
    chk("rst_addr", bus.wr_addr, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_busy", bus.busy, 0);
    tick();

    // streaming, 5 frames of clamped length 16
    begin : stream
      int nwr = 0;
      int nrd = 0;
      int nv = 0;
      int nl = 0;
      int tog = 0;
      int low = 0;
      int bad = 0;
      int wfd = 0;
      int rfd = 0;
      logic pc;
      bit fin = 0;
      do_reset();
      bus.cfg_len = 5'd0;
      bus.out_req = 1'b1;
      pc = 1'b0;
      for (int c = 0; c < 400 && !fin; c++) begin
        bus.in_valid = (nwr < 80);
        @(negedge clk);
        if (bus.wr_en) begin
          if (bus.wr_addr != nwr[3:0]) bad++;
          nwr++;
        end
        if (bus.rd_en) begin
          if (bus.rd_addr != nrd[3:0]) bad++;
          nrd++;
        end
        if (bus.rd_data_valid) nv++;
        if (bus.rd_data_last) nl++;
        if (bus.wr_frame_done) wfd++;
        if (bus.rd_frame_done) rfd++;
        if (bus.ctrl != pc) tog++;
        pc = bus.ctrl;
        if (bus.in_valid && !bus.in_ready) low++;
        if (nv == 80 && !bus.busy) fin = 1;
        tick();
      end
      chk("st_finished", fin, 1);
      chk("st_writes", nwr, 80);
      chk("st_reads", nrd, 80);
      chk("st_valid", nv, 80);
      chk("st_last", nl, 5);
      chk("st_order", bad, 0);
      chk("st_toggles", tog, 5);
      chk("st_stalls", low, 4);
      chk("st_wfd", wfd, 5);
      chk("st_rfd", rfd, 5);
      chk("st_ctrl", bus.ctrl, 1);
    end

    // back-pressure: two frames of 8, no reads
    begin : bp
      int nwr = 0;
      int nrd = 0;
      int nv = 0;
      int low = 0;
      int bad = 0;
      int rfd = 0;
      bit fin = 0;
      do_reset();
      bus.cfg_len = 5'd8;
      for (int c = 0; c < 30; c++) begin
        bus.in_valid = (nwr < 16);
        @(negedge clk);
        if (bus.wr_en) nwr++;
        if (bus.rd_en) nrd++;
        tick();
      end
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("bp_accepted", nwr, 16);
      chk("bp_no_reads", nrd, 0);
      chk("bp_stalled", bus.in_ready, 0);
      tick();
      bus.out_req = 1'b1;
      for (int c = 0; c < 40 && !fin; c++) begin
        @(negedge clk);
        if (bus.rd_en) begin
          if (bus.rd_addr != nrd[2:0]) bad++;
          nrd++;
        end
        if (bus.rd_data_valid) nv++;
        if (bus.rd_frame_done) rfd++;
        if (bus.in_ready) fin = 1;
        else low++;
        tick();
      end
      chk("bp_low_cycles", low, 9);
      fin = 0;
      for (int c = 0; c < 60 && !fin; c++) begin
        @(negedge clk);
        if (bus.rd_en) begin
          if (bus.rd_addr != nrd[2:0]) bad++;
          nrd++;
        end
        if (bus.rd_data_valid) nv++;
        if (bus.rd_frame_done) rfd++;
        if (nv == 16 && !bus.busy) fin = 1;
        tick();
      end
      chk("bp_drained", fin, 1);
      chk("bp_reads", nrd, 16);
      chk("bp_valid", nv, 16);
      chk("bp_order", bad, 0);
      chk("bp_rfd", rfd, 2);
    end

    // flush with frame partly written and reads in flight
    do_reset();
    bus.cfg_len  = 5'd4;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("fl_swap_rdy", bus.in_ready, 0);
    tick();
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("fl_w0_addr", bus.wr_addr, 0);
    chk("fl_w0_ctrl", bus.ctrl, 1);
    tick();
    bus.out_req = 1'b1;
    @(negedge clk);
    chk("fl_w1_addr", bus.wr_addr, 1);
    chk("fl_r0_en", bus.rd_en, 1);
    chk("fl_r0_addr", bus.rd_addr, 0);
    tick();
    @(negedge clk);
    chk("fl_w2_addr", bus.wr_addr, 2);
    chk("fl_r1_addr", bus.rd_addr, 1);
    tick();
    bus.flush = 1'b1;
    @(negedge clk);
    chk("fl_wr_blk", bus.wr_en, 0);
    chk("fl_rd_blk", bus.rd_en, 0);
    chk("fl_rdy", bus.in_ready, 0);
    chk("fl_rdv0", bus.rd_data_valid, 1);
    tick();
    bus.flush = 1'b0;
    @(negedge clk);
    chk("fl_rdv1", bus.rd_data_valid, 1);
    chk("fl_rd_idle", bus.rd_en, 0);
    chk("fl_wr_en", bus.wr_en, 1);
    chk("fl_wr_addr", bus.wr_addr, 0);
    chk("fl_ctrl", bus.ctrl, 1);
    tick();
    bus.in_valid = 1'b0;
    bus.out_req  = 1'b0;
    @(negedge clk);
    chk("fl_rdv2", bus.rd_data_valid, 0);
    tick();

    // length change mid-frame
    begin : lc
      int nrd = 0;
      int d1 = 0;
      int d2 = 0;
      bit fin = 0;
      do_reset();
      bus.cfg_len  = 5'd6;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
        if (i == 2) bus.cfg_len = 5'd3;
        @(negedge clk);
        chk("lc_f1_addr", bus.wr_addr, i);
        chk("lc_f1_wfd", bus.wr_frame_done, i == 5);
        tick();
      end
      @(negedge clk);
      chk("lc_swap_rdy", bus.in_ready, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("lc_f2_addr", bus.wr_addr, i);
        chk("lc_f2_wfd", bus.wr_frame_done, i == 2);
        tick();
      end
      bus.in_valid = 1'b0;
      bus.out_req  = 1'b1;
      for (int c = 0; c < 40 && !fin; c++) begin
        @(negedge clk);
        if (bus.rd_en) begin
          nrd++;
          if (bus.rd_frame_done) begin
            if (d1 == 0) d1 = nrd;
            else d2 = nrd;
          end
        end
        if (nrd == 9 && !bus.busy) fin = 1;
        tick();
      end
      chk("lc_drained", fin, 1);
      chk("lc_rfd1", d1, 6);
      chk("lc_rfd2", d2, 9);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
